// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: ID decode, DEPTH control-word stages, bubble/flush/freeze/halt.
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_ctrl_unit #(
    parameter int DEPTH   = 3,
    parameter int PCSRC_W = 3,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               id_valid,
    input  logic               stall_in,
    input  logic               flush_in,
    input  logic               zero,
    input  logic               overflow,
    input  logic               negative,
    input  logic               dhit,
    output logic [3:0]         ex_aluop,
    output logic               ex_alusrc,
    output logic               ex_extop,
    output logic [PCSRC_W-1:0] pc_sel,
    output logic               dmemreq,
    output logic               dmemwreq,
    output logic               imemreq,
    output logic               mem_stall,
    output logic               wb_regwen,
    output logic [1:0]         wb_regdest,
    output logic [1:0]         wb_memtoreg,
    output logic               halt,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03,
                           OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI  = 6'h08,
                           OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b,
                           OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_XORI  = 6'h0e,
                           OP_LUI   = 6'h0f, OP_LW   = 6'h23, OP_SW    = 6'h2b,
                           OP_HALT  = 6'h3f;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08,
                           FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22,
                           FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                           FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2a,
                           FN_SLTU = 6'h2b;

    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB  = 4'd3,
                           ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR  = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       extop;
        logic       beq;
        logic       bne;
        logic       jmp;
        logic       jr;
        logic       memread;
        logic       memwrite;
        logic       regwen;
        logic [1:0] regdest;
        logic [1:0] memtoreg;
        logic       halt;
        logic       ovf_chk;
    } cw_t;

    localparam cw_t CW_NOP = '0;

    cw_t  dec;
    cw_t  id_next;
    cw_t  ex_out;
    cw_t  cw [DEPTH];
    logic halt_seen;
    logic advance;

    always_comb begin
        dec = CW_NOP;
        case (opcode)
            OP_RTYPE: begin
                dec.regwen  = 1'b1;
                dec.regdest = 2'd1;
                case (funct)
                    FN_SLL:  dec.aluop = ALU_SLL;
                    FN_SRL:  dec.aluop = ALU_SRL;
                    FN_ADD:  begin dec.aluop = ALU_ADD; dec.ovf_chk = 1'b1; end
                    FN_ADDU: dec.aluop = ALU_ADD;
                    FN_SUB:  begin dec.aluop = ALU_SUB; dec.ovf_chk = 1'b1; end
                    FN_SUBU: dec.aluop = ALU_SUB;
                    FN_AND:  dec.aluop = ALU_AND;
                    FN_OR:   dec.aluop = ALU_OR;
                    FN_XOR:  dec.aluop = ALU_XOR;
                    FN_NOR:  dec.aluop = ALU_NOR;
                    FN_SLT:  dec.aluop = ALU_SLT;
                    FN_SLTU: dec.aluop = ALU_SLTU;
                    FN_JR:   begin dec = CW_NOP; dec.jr = 1'b1; end
                    default: dec = CW_NOP;
                endcase
            end
            OP_J:     dec.jmp = 1'b1;
            OP_JAL:   begin dec.jmp = 1'b1; dec.regwen = 1'b1; dec.regdest = 2'd2; dec.memtoreg = 2'd2; end
            OP_BEQ:   begin dec.beq = 1'b1; dec.aluop = ALU_SUB; dec.extop = 1'b1; end
            OP_BNE:   begin dec.bne = 1'b1; dec.aluop = ALU_SUB; dec.extop = 1'b1; end
            OP_ADDI:  begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.extop = 1'b1;
                            dec.regwen = 1'b1; dec.ovf_chk = 1'b1; end
            OP_ADDIU: begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.regwen = 1'b1; end
            OP_SLTI:  begin dec.aluop = ALU_SLT; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.regwen = 1'b1; end
            OP_SLTIU: begin dec.aluop = ALU_SLTU; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.regwen = 1'b1; end
            OP_ANDI:  begin dec.aluop = ALU_AND; dec.alusrc = 1'b1; dec.regwen = 1'b1; end
            OP_ORI:   begin dec.aluop = ALU_OR;  dec.alusrc = 1'b1; dec.regwen = 1'b1; end
            OP_XORI:  begin dec.aluop = ALU_XOR; dec.alusrc = 1'b1; dec.regwen = 1'b1; end
            OP_LUI:   begin dec.alusrc = 1'b1; dec.regwen = 1'b1; dec.memtoreg = 2'd3; end
            OP_LW:    begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.extop = 1'b1;
                            dec.memread = 1'b1; dec.regwen = 1'b1; dec.memtoreg = 2'd1; end
            OP_SW:    begin dec.aluop = ALU_ADD; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.memwrite = 1'b1; end
            OP_HALT:  dec.halt = 1'b1;
            default:  dec = CW_NOP;
        endcase
    end

    // Flush wins over stall; both only matter on an advancing edge.
    assign id_next = (flush_in || stall_in || !id_valid) ? CW_NOP : dec;

    always_comb begin
        ex_out = cw[0];
        if (cw[0].ovf_chk && overflow)
            ex_out.regwen = 1'b0;
    end

    assign dmemreq   = cw[DEPTH-2].memread  & ~halt;
    assign dmemwreq  = cw[DEPTH-2].memwrite & ~halt;
    assign mem_stall = (dmemreq | dmemwreq) & ~dhit;
    assign advance   = ~mem_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                cw[k] <= CW_NOP;
            halt_seen <= 1'b0;
            halt      <= 1'b0;
        end else if (advance) begin
            cw[0] <= id_next;
            cw[1] <= ex_out;
            for (int k = 2; k < DEPTH; k++)
                cw[k] <= cw[k-1];
            if (id_next.halt)
                halt_seen <= 1'b1;
            if (cw[DEPTH-2].halt)
                halt <= 1'b1;
        end
    end

    always_comb begin
        pc_sel = '0;
        if ((cw[0].beq && zero) || (cw[0].bne && !zero))
            pc_sel = PCSRC_W'(1);
        else if (cw[0].jmp)
            pc_sel = PCSRC_W'(2);
        else if (cw[0].jr)
            pc_sel = PCSRC_W'(3);
    end

    assign ex_aluop    = cw[0].aluop;
    assign ex_alusrc   = cw[0].alusrc;
    assign ex_extop    = cw[0].extop;
    assign imemreq     = ~halt_seen;
    assign wb_regwen   = cw[DEPTH-1].regwen & ~halt;
    assign wb_regdest  = cw[DEPTH-1].regdest;
    assign wb_memtoreg = cw[DEPTH-1].memtoreg;

    // negative is reserved; WB only consumes its write-back fields.
    logic unused_bits;
    assign unused_bits = ^{negative, cw[DEPTH-1]};

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!halt) begin
            if ((mem_stall || stall_in) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_in && !mem_stall && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: queue-based reference model, randomized and directed stimulus.
module tb_pipe_ctrl_unit;

    localparam int DEPTH = 3;

    localparam int K_NOP = 0, K_ALU = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_BNE = 5, K_J = 6, K_JR = 7, K_HALT = 8;

    typedef struct packed {
        logic [3:0] kind;
        logic       rw;
        logic [1:0] rd;
        logic [1:0] mtr;
        logic [3:0] alu;
        logic       src;
        logic       ext;
        logic       ovfs;
    } ins_t;

    typedef struct packed {
        logic        chk_wb;
        logic        ms;
        logic        dreq;
        logic        dwreq;
        logic        imem;
        logic        hlt;
        logic [2:0]  pcs;
        logic [3:0]  alu;
        logic        src;
        logic        ext;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } cyc_t;

    typedef struct packed {
        logic       rw;
        logic [1:0] rd;
        logic [1:0] mtr;
    } wb_t;

    logic clk = 1'b0;
    logic rst, id_valid, stall_in, flush_in, zero, overflow, negative, dhit;
    logic [5:0] opcode, funct;
    logic [3:0] ex_aluop;
    logic ex_alusrc, ex_extop, dmemreq, dmemwreq, imemreq, mem_stall, wb_regwen, halt;
    logic [2:0] pc_sel;
    logic [1:0] wb_regdest, wb_memtoreg;
    logic [31:0] stall_cnt, flush_cnt;

    pipe_ctrl_unit #(.DEPTH(DEPTH), .PCSRC_W(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .id_valid(id_valid),
        .stall_in(stall_in), .flush_in(flush_in), .zero(zero), .overflow(overflow),
        .negative(negative), .dhit(dhit), .ex_aluop(ex_aluop), .ex_alusrc(ex_alusrc),
        .ex_extop(ex_extop), .pc_sel(pc_sel), .dmemreq(dmemreq), .dmemwreq(dmemwreq),
        .imemreq(imemreq), .mem_stall(mem_stall), .wb_regwen(wb_regwen),
        .wb_regdest(wb_regdest), .wb_memtoreg(wb_memtoreg), .halt(halt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    cyc_t cyc_q [$];
    wb_t  wb_q  [$];

    // Reference model state: instructions in flight, newest first.
    ins_t pipe [$];
    bit   halt_m, hseen_m, ovf_m, last_adv;
    int   scnt_m, fcnt_m;

    function automatic ins_t mk(int kind, bit rw, int rd, int mtr, int alu, bit src, bit ext, bit ovfs);
        ins_t i;
        i.kind = 4'(kind); i.rw = rw; i.rd = 2'(rd); i.mtr = 2'(mtr);
        i.alu = 4'(alu); i.src = src; i.ext = ext; i.ovfs = ovfs;
        return i;
    endfunction

    function automatic ins_t decode(logic [5:0] op, logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                6'h00: return mk(K_ALU, 1, 1, 0, 0, 0, 0, 0);
                6'h02: return mk(K_ALU, 1, 1, 0, 1, 0, 0, 0);
                6'h08: return mk(K_JR,  0, 0, 0, 0, 0, 0, 0);
                6'h20: return mk(K_ALU, 1, 1, 0, 2, 0, 0, 1);
                6'h21: return mk(K_ALU, 1, 1, 0, 2, 0, 0, 0);
                6'h22: return mk(K_ALU, 1, 1, 0, 3, 0, 0, 1);
                6'h23: return mk(K_ALU, 1, 1, 0, 3, 0, 0, 0);
                6'h24: return mk(K_ALU, 1, 1, 0, 4, 0, 0, 0);
                6'h25: return mk(K_ALU, 1, 1, 0, 5, 0, 0, 0);
                6'h26: return mk(K_ALU, 1, 1, 0, 6, 0, 0, 0);
                6'h27: return mk(K_ALU, 1, 1, 0, 7, 0, 0, 0);
                6'h2a: return mk(K_ALU, 1, 1, 0, 8, 0, 0, 0);
                6'h2b: return mk(K_ALU, 1, 1, 0, 9, 0, 0, 0);
                default: return '0;
            endcase
            6'h02: return mk(K_J,    0, 0, 0, 0, 0, 0, 0);
            6'h03: return mk(K_J,    1, 2, 2, 0, 0, 0, 0);
            6'h04: return mk(K_BEQ,  0, 0, 0, 3, 0, 1, 0);
            6'h05: return mk(K_BNE,  0, 0, 0, 3, 0, 1, 0);
            6'h08: return mk(K_ALU,  1, 0, 0, 2, 1, 1, 1);
            6'h09: return mk(K_ALU,  1, 0, 0, 2, 1, 1, 0);
            6'h0a: return mk(K_ALU,  1, 0, 0, 8, 1, 1, 0);
            6'h0b: return mk(K_ALU,  1, 0, 0, 9, 1, 1, 0);
            6'h0c: return mk(K_ALU,  1, 0, 0, 4, 1, 0, 0);
            6'h0d: return mk(K_ALU,  1, 0, 0, 5, 1, 0, 0);
            6'h0e: return mk(K_ALU,  1, 0, 0, 6, 1, 0, 0);
            6'h0f: return mk(K_ALU,  1, 0, 3, 0, 1, 0, 0);
            6'h23: return mk(K_LW,   1, 0, 1, 2, 1, 1, 0);
            6'h2b: return mk(K_SW,   0, 0, 0, 2, 1, 1, 0);
            6'h3f: return mk(K_HALT, 0, 0, 0, 0, 0, 0, 0);
            default: return '0;
        endcase
    endfunction

    function automatic logic [2:0] pcs_of(ins_t i, logic z);
        if (i.kind == 4'(K_BEQ)) return z ? 3'd1 : 3'd0;
        if (i.kind == 4'(K_BNE)) return z ? 3'd0 : 3'd1;
        if (i.kind == 4'(K_J))   return 3'd2;
        if (i.kind == 4'(K_JR))  return 3'd3;
        return 3'd0;
    endfunction

    task automatic step(bit r, bit v, logic [5:0] op, logic [5:0] fn,
                        bit st, bit fl, bit z, bit dh, bit ov);
        cyc_t c;
        ins_t nw;
        wb_t  w;
        rst = r; id_valid = v; opcode = op; funct = fn;
        stall_in = st; flush_in = fl; zero = z; dhit = dh;
        negative = 1'($urandom_range(0, 1));
        if (r) begin
            pipe.delete();
            repeat (DEPTH) pipe.push_back('0);
            wb_q.delete();
            repeat (DEPTH) wb_q.push_back('0);
            halt_m = 0; hseen_m = 0; ovf_m = 0; last_adv = 0; scnt_m = 0; fcnt_m = 0;
        end
        overflow = ovf_m;
        c = '0;
        c.chk_wb = r ? 1'b1 : last_adv;
        c.dreq   = (pipe[DEPTH-2].kind == 4'(K_LW)) && !halt_m;
        c.dwreq  = (pipe[DEPTH-2].kind == 4'(K_SW)) && !halt_m;
        c.ms     = (c.dreq || c.dwreq) && !dh;
        c.pcs    = pcs_of(pipe[0], z);
        c.alu    = pipe[0].alu;
        c.src    = pipe[0].src;
        c.ext    = pipe[0].ext;
        c.imem   = !hseen_m;
        c.hlt    = halt_m;
`ifdef PIPE_CTRL_PERF_EN
        c.scnt = 32'(scnt_m);
        c.fcnt = 32'(fcnt_m);
`endif
        cyc_q.push_back(c);
        if (!r) begin
            if (!halt_m) begin
                if (c.ms || st) scnt_m++;
                if (fl && !c.ms) fcnt_m++;
            end
            last_adv = !c.ms;
            if (!c.ms) begin
                if (pipe[DEPTH-2].kind == 4'(K_HALT)) halt_m = 1;
                nw = (v && !st && !fl) ? decode(op, fn) : '0;
                if (nw.kind == 4'(K_HALT)) hseen_m = 1;
                w.rw  = nw.rw & ~(nw.ovfs & ov);
                w.rd  = nw.rd;
                w.mtr = nw.mtr;
                wb_q.push_back(w);
                pipe.push_front(nw);
                void'(pipe.pop_back());
                ovf_m = ov;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
    endtask

    function automatic logic [5:0] rand_op();
        int s = int'($urandom_range(0, 63));
        if (s == 0) return 6'h3f;
        if (s < 4)  return 6'($urandom_range(0, 63));
        case ($urandom_range(0, 16))
            0, 1, 2: return 6'h00;
            3:  return 6'h02;  4:  return 6'h03;  5:  return 6'h04;  6:  return 6'h05;
            7:  return 6'h08;  8:  return 6'h09;  9:  return 6'h0a;  10: return 6'h0c;
            11: return 6'h0d;  12: return 6'h0f;  13: return 6'h23;  14: return 6'h2b;
            15: return 6'h23;  default: return 6'h0e;
        endcase
    endfunction

    function automatic logic [5:0] rand_fn();
        case ($urandom_range(0, 13))
            0: return 6'h00;  1: return 6'h02;  2: return 6'h08;  3: return 6'h20;
            4: return 6'h21;  5: return 6'h22;  6: return 6'h23;  7: return 6'h24;
            8: return 6'h25;  9: return 6'h27;  10: return 6'h2a; 11: return 6'h2b;
            12: return 6'h26; default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    cyc_t mc;
    wb_t  mw;
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mc = cyc_q.pop_front();
            chk("mem_stall", 32'(mem_stall), 32'(mc.ms));
            chk("dmemreq",   32'(dmemreq),   32'(mc.dreq));
            chk("dmemwreq",  32'(dmemwreq),  32'(mc.dwreq));
            chk("imemreq",   32'(imemreq),   32'(mc.imem));
            chk("halt",      32'(halt),      32'(mc.hlt));
            chk("pc_sel",    32'(pc_sel),    32'(mc.pcs));
            chk("ex_aluop",  32'(ex_aluop),  32'(mc.alu));
            chk("ex_alusrc", 32'(ex_alusrc), 32'(mc.src));
            chk("ex_extop",  32'(ex_extop),  32'(mc.ext));
            chk("stall_cnt", stall_cnt,      mc.scnt);
            chk("flush_cnt", flush_cnt,      mc.fcnt);
            if (mc.chk_wb) begin
                if (wb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wb_scoreboard: got empty queue expected an entry at %0t", $time);
                end else begin
                    mw = wb_q.pop_front();
                    chk("wb_regwen",   32'(wb_regwen),   32'(mw.rw & ~mc.hlt));
                    chk("wb_regdest",  32'(wb_regdest),  32'(mw.rd));
                    chk("wb_memtoreg", 32'(wb_memtoreg), 32'(mw.mtr));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; id_valid = 0; opcode = '0; funct = '0; stall_in = 0; flush_in = 0;
        zero = 0; overflow = 0; negative = 0; dhit = 1;
        @(posedge clk);
        #1;
        step(1, 0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
        step(1, 0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
        // ADDU reaches WB with rd write; overflow ignored for unsigned ops
        step(0, 1, 6'h00, 6'h21, 0, 0, 0, 1, 1);
        idle(DEPTH);
        // signed ops with overflow lose their write; ADDIU does not
        step(0, 1, 6'h00, 6'h20, 0, 0, 0, 1, 1);
        step(0, 1, 6'h08, 6'h00, 0, 0, 0, 1, 1);
        step(0, 1, 6'h00, 6'h22, 0, 0, 0, 1, 0);
        step(0, 1, 6'h09, 6'h00, 0, 0, 0, 1, 1);
        idle(DEPTH);
        // LW waits 3 cycles with stall+flush asserted throughout, then back-to-back memory ops
        step(0, 1, 6'h23, 6'h00, 0, 0, 0, 1, 0);
        repeat (DEPTH - 2) step(0, 1, 6'h00, 6'h25, 0, 0, 0, 1, 0);
        repeat (3) step(0, 1, 6'h00, 6'h24, 1, 1, 0, 0, 0);
        step(0, 1, 6'h23, 6'h00, 0, 0, 0, 1, 0);
        step(0, 1, 6'h2b, 6'h00, 0, 0, 0, 1, 0);
        step(0, 1, 6'h23, 6'h00, 0, 0, 0, 1, 0);
        idle(DEPTH + 1);
        // branches, jumps and a flush killing the instruction behind a taken BEQ
        step(0, 1, 6'h04, 6'h00, 0, 0, 0, 1, 0);
        step(0, 1, 6'h00, 6'h21, 0, 1, 1, 1, 0);
        step(0, 1, 6'h05, 6'h00, 0, 0, 0, 1, 0);
        step(0, 1, 6'h03, 6'h00, 0, 0, 0, 1, 0);
        step(0, 1, 6'h00, 6'h08, 0, 0, 1, 1, 0);
        step(0, 1, 6'h02, 6'h00, 0, 0, 0, 1, 0);
        step(0, 1, 6'h0f, 6'h00, 0, 0, 0, 1, 0);
        step(0, 1, 6'h3f, 6'h00, 0, 1, 0, 1, 0);
        idle(DEPTH + 1);
        // HALT: fetch stops, halt after DEPTH edges, later SW and writes suppressed
        step(0, 1, 6'h3f, 6'h00, 0, 0, 0, 1, 0);
        step(0, 1, 6'h00, 6'h21, 0, 0, 0, 1, 0);
        step(0, 1, 6'h2b, 6'h00, 0, 0, 0, 0, 0);
        step(0, 1, 6'h23, 6'h00, 1, 0, 0, 0, 0);
        step(0, 1, 6'h00, 6'h25, 0, 1, 0, 0, 0);
        idle(DEPTH);
        step(1, 0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
        idle(2);
        // random episodes, each started by a reset that may land mid memory wait
        for (int e = 0; e < 25; e++) begin
            repeat ($urandom_range(1, 2)) step(1, 0, 6'h00, 6'h00, 0, 0, 0, 1, 0);
            for (int n = 0; n < 60; n++)
                step(0, ($urandom_range(0, 7) != 0), rand_op(), rand_fn(),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
